gestor_turnos: RTL and testbench
================================

# gestor_turnos

Parametrised turn manager for the board-game datapath. Lets the players cycle the starting player among `N_JUGADORES` candidates with a button, locks the choice on game start, then rotates the active player on every valid move. Enforces a per-turn timeout and declares a draw when the board's move budget is exhausted. Sits between the button/input conditioning logic and the board/VGA controllers, which consume `jugador_actual`, `listo` and the end-of-game flags.

## Interface
- `N_JUGADORES`, 2, number of players (≥2); IDs 0..N_JUGADORES-1, 0 = rojo, 1 = amarillo.
- `TIMEOUT_CICLOS`, 500_000_000, clock cycles allowed per turn (≥2).
- `MAX_TURNOS`, 42, valid moves before a draw is declared (≥1).
- Derived widths: JW = max(1, $clog2(N_JUGADORES)); TW = $clog2(TIMEOUT_CICLOS); CW = $clog2(MAX_TURNOS+1).

Ports:
- `clk`  in  1  single system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `boton_elegir`  in  1  raw button, asynchronous to `clk`; rising edge advances the candidate.
- `iniciar_juego`  in  1  sampled level; locks the candidate and starts play.
- `jugada_valida`  in  1  one-cycle pulse from the board: current player placed a piece.
- `fin_juego`  in  1  one-cycle pulse from the win detector.
- `jugador_inicial`  out  JW  locked starting player.
- `jugador_actual`  out  JW  candidate in SELECCION, active player otherwise.
- `listo`  out  1  1 whenever state ≠ SELECCION.
- `turno_expirado`  out  1  one-cycle pulse on timeout.
- `tiempo_restante`  out  TW  cycles left in the current turn.
- `numero_turno`  out  CW  valid moves played this game.
- `empate`  out  1  1 in FIN when the game ended by move budget.

## Operation
- States: SELECCION, JUGANDO, FIN.
- Reset (async assert, sync release) values: state SELECCION, candidate 0, `jugador_inicial` 0, `jugador_actual` 0, `listo` 0, `turno_expirado` 0, `tiempo_restante` 0, `numero_turno` 0, `empate` 0.
- `boton_elegir` passes through a 2-flop synchroniser plus an edge register. A rising edge (`flanco`) is acted on only in SELECCION and FIN.
- SELECCION:
  - `flanco` increments the candidate modulo N_JUGADORES, wrapping N-1→0.
  - `iniciar_juego` copies the candidate to `jugador_inicial` and `jugador_actual`.
  - It also loads `tiempo_restante` = TIMEOUT_CICLOS-1, clears `numero_turno` and `empate`, and moves to JUGANDO.
  - If `flanco` and `iniciar_juego` arrive in the same cycle, `iniciar_juego` wins and the pre-increment candidate is locked.
- JUGANDO, in priority order each cycle:
  1. `fin_juego`: go to FIN with `empate` 0. A same-cycle `jugada_valida` is ignored.
  2. `jugada_valida`: `numero_turno`+1, advance player modulo N, reload the timer. If the new count equals MAX_TURNOS, go to FIN with `empate` 1.
  3. `tiempo_restante` == 0: advance player, reload the timer, pulse `turno_expirado`. `numero_turno` is unchanged.
  4. Otherwise decrement `tiempo_restante`.
- A `jugada_valida` arriving in the same cycle as timer 0 counts as a move; no expiry.
- `iniciar_juego` and `flanco` have no effect in JUGANDO.
- FIN:
  - All outputs hold; `turno_expirado` stays 0.
  - `flanco` returns to SELECCION with candidate = (`jugador_inicial`+1) mod N, which rotates the opener.
  - `listo` drops to 0 in the same transition.
- Reset mid-game aborts immediately to the reset values above.

## Timing
- Button press to candidate change: 3 cycles after `boton_elegir` rises (2 sync + 1 edge).
- `iniciar_juego` high in cycle t gives `listo` = 1 and a valid `jugador_inicial` in cycle t+1.
- `jugada_valida` in cycle t gives the new `jugador_actual` and `numero_turno` at t+1.
- A turn with no move lasts exactly TIMEOUT_CICLOS cycles. `turno_expirado` is high for the single cycle after `tiempo_restante` was 0.
- All outputs are registered; no combinational input→output paths.

## Structure
- `gestor_turnos_pkg` holds the `estado_t` enum {SELECCION, JUGANDO, FIN} and a `siguiente_jugador(id, n)` modulo-increment function.
- One sub-module, `detector_flanco`: 2-flop synchroniser plus rising-edge pulse, clocked by `clk` with reset `reset_n`. It is reused for other buttons.
- The state machine, timer and counters live in the top module.

## Test plan
- N=3: three button presses (candidate 0→1→2→0), a fourth press → 1, then `iniciar_juego` → `jugador_inicial`=1, `listo`=1 one cycle later.
- N=2, TIMEOUT=10: start with 0, no moves → `turno_expirado` pulses after 10 cycles, `jugador_actual`=1, `numero_turno`=0.
- MAX_TURNOS=4: four `jugada_valida` pulses → players 0,1,0,1→0; `empate`=1, state FIN, `numero_turno`=4.
- `jugada_valida` on the cycle `tiempo_restante`=0 → no `turno_expirado`, `numero_turno`+1, timer reloaded to TIMEOUT-1.
- Same-cycle `flanco`+`iniciar_juego` with candidate 1 locks 1. In JUGANDO, same-cycle `fin_juego`+`jugada_valida` → FIN, `empate`=0, count unchanged.
- Press in FIN → SELECCION, candidate = `jugador_inicial`+1. `reset_n` low mid-JUGANDO → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/gestor_turnos_pkg.sv
// Shared types and helpers for the turn manager: FSM state encoding and
// the modulo player-advance function.
package gestor_turnos_pkg;

    typedef enum logic [1:0] {
        SELECCION = 2'd0,
        JUGANDO   = 2'd1,
        FIN       = 2'd2
    } estado_t;

    function automatic int unsigned siguiente_jugador(input int unsigned id,
                                                      input int unsigned n);
        if (id + 32'd1 >= n) begin
            siguiente_jugador = 32'd0;
        end else begin
            siguiente_jugador = id + 32'd1;
        end
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Button conditioner: two-flop synchroniser for an asynchronous level plus
// a one-cycle pulse on its rising edge.
module detector_flanco (
    input  logic clk,
    input  logic reset_n,
    input  logic entrada,
    output logic flanco
);

    logic sync1_r;
    logic sync2_r;
    logic previo_r;

    // Synchroniser chain followed by the edge-history register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            previo_r <= 1'b0;
        end else begin
            sync1_r  <= entrada;
            sync2_r  <= sync1_r;
            previo_r <= sync2_r;
        end
    end

    assign flanco = sync2_r & ~previo_r;

endmodule

// File: rtl/gestor_turnos.sv
// Turn manager: starting-player selection, active-player rotation, per-turn
// timeout and move-budget draw detection.
module gestor_turnos
    import gestor_turnos_pkg::*;
#(
    parameter int unsigned  N_JUGADORES    = 2,
    parameter int unsigned  TIMEOUT_CICLOS = 500_000_000,
    parameter int unsigned  MAX_TURNOS     = 42,
    localparam int unsigned JW = (N_JUGADORES > 2) ? $clog2(N_JUGADORES) : 1,
    localparam int unsigned TW = $clog2(TIMEOUT_CICLOS),
    localparam int unsigned CW = $clog2(MAX_TURNOS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          boton_elegir,
    input  logic          iniciar_juego,
    input  logic          jugada_valida,
    input  logic          fin_juego,
    output logic [JW-1:0] jugador_inicial,
    output logic [JW-1:0] jugador_actual,
    output logic          listo,
    output logic          turno_expirado,
    output logic [TW-1:0] tiempo_restante,
    output logic [CW-1:0] numero_turno,
    output logic          empate
);

    localparam logic [TW-1:0] RECARGA = TW'(TIMEOUT_CICLOS - 32'd1);
    localparam logic [CW-1:0] LIMITE  = CW'(MAX_TURNOS);

    estado_t       estado_r, estado_s;
    logic [JW-1:0] jugador_actual_r, jugador_actual_s;
    logic [JW-1:0] jugador_inicial_r, jugador_inicial_s;
    logic [TW-1:0] tiempo_r, tiempo_s;
    logic [CW-1:0] numero_r, numero_s;
    logic          empate_r, empate_s;
    logic          expirado_r, expirado_s;
    logic          listo_r;
    logic          flanco_s;
    logic [JW-1:0] siguiente_s;
    logic [JW-1:0] rotacion_s;
    logic [CW-1:0] numero_inc_s;

    detector_flanco u_flanco (
        .clk     (clk),
        .reset_n (reset_n),
        .entrada (boton_elegir),
        .flanco  (flanco_s)
    );

    // In SELECCION jugador_actual_r doubles as the candidate register
    assign siguiente_s  = JW'(siguiente_jugador(32'(jugador_actual_r), N_JUGADORES));
    assign rotacion_s   = JW'(siguiente_jugador(32'(jugador_inicial_r), N_JUGADORES));
    assign numero_inc_s = numero_r + CW'(1);

    // Next-state and next-value logic for the turn FSM
    always_comb begin
        estado_s          = estado_r;
        jugador_actual_s  = jugador_actual_r;
        jugador_inicial_s = jugador_inicial_r;
        tiempo_s          = tiempo_r;
        numero_s          = numero_r;
        empate_s          = empate_r;
        expirado_s        = 1'b0;
        case (estado_r)
            SELECCION: begin
                if (iniciar_juego) begin
                    jugador_inicial_s = jugador_actual_r;
                    tiempo_s          = RECARGA;
                    numero_s          = {CW{1'b0}};
                    empate_s          = 1'b0;
                    estado_s          = JUGANDO;
                end else if (flanco_s) begin
                    jugador_actual_s = siguiente_s;
                end else begin
                    estado_s = SELECCION;
                end
            end
            JUGANDO: begin
                if (fin_juego) begin
                    empate_s = 1'b0;
                    estado_s = FIN;
                end else if (jugada_valida) begin
                    numero_s         = numero_inc_s;
                    jugador_actual_s = siguiente_s;
                    tiempo_s         = RECARGA;
                    if (numero_inc_s == LIMITE) begin
                        empate_s = 1'b1;
                        estado_s = FIN;
                    end else begin
                        estado_s = JUGANDO;
                    end
                end else if (tiempo_r == {TW{1'b0}}) begin
                    jugador_actual_s = siguiente_s;
                    tiempo_s         = RECARGA;
                    expirado_s       = 1'b1;
                end else begin
                    tiempo_s = tiempo_r - TW'(1);
                end
            end
            FIN: begin
                if (flanco_s) begin
                    jugador_actual_s = rotacion_s;
                    estado_s         = SELECCION;
                end else begin
                    estado_s = FIN;
                end
            end
            default: begin
                estado_s = SELECCION;
            end
        endcase
    end

    // State, player, timer and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_r          <= SELECCION;
            jugador_actual_r  <= {JW{1'b0}};
            jugador_inicial_r <= {JW{1'b0}};
            tiempo_r          <= {TW{1'b0}};
            numero_r          <= {CW{1'b0}};
            empate_r          <= 1'b0;
            expirado_r        <= 1'b0;
            listo_r           <= 1'b0;
        end else begin
            estado_r          <= estado_s;
            jugador_actual_r  <= jugador_actual_s;
            jugador_inicial_r <= jugador_inicial_s;
            tiempo_r          <= tiempo_s;
            numero_r          <= numero_s;
            empate_r          <= empate_s;
            expirado_r        <= expirado_s;
            listo_r           <= (estado_s != SELECCION);
        end
    end

    assign jugador_inicial = jugador_inicial_r;
    assign jugador_actual  = jugador_actual_r;
    assign listo           = listo_r;
    assign turno_expirado  = expirado_r;
    assign tiempo_restante = tiempo_r;
    assign numero_turno    = numero_r;
    assign empate          = empate_r;

endmodule

// File: tb/tb_gestor_turnos.sv
// Self-checking bench for gestor_turnos: directed vector table, hand-written
// corner sequences and random stimulus against a behavioural model.
module tb_gestor_turnos;

    localparam int N  = 3;
    localparam int T  = 10;
    localparam int M  = 4;
    localparam int JW = 2;
    localparam int TW = 4;
    localparam int CW = 3;
    localparam int S_SEL = 0;
    localparam int S_JUG = 1;
    localparam int S_FIN = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          boton_elegir = 1'b0;
    logic          iniciar_juego = 1'b0;
    logic          jugada_valida = 1'b0;
    logic          fin_juego = 1'b0;
    logic [JW-1:0] jugador_inicial;
    logic [JW-1:0] jugador_actual;
    logic          listo;
    logic          turno_expirado;
    logic [TW-1:0] tiempo_restante;
    logic [CW-1:0] numero_turno;
    logic          empate;

    gestor_turnos #(
        .N_JUGADORES    (N),
        .TIMEOUT_CICLOS (T),
        .MAX_TURNOS     (M)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .boton_elegir    (boton_elegir),
        .iniciar_juego   (iniciar_juego),
        .jugada_valida   (jugada_valida),
        .fin_juego       (fin_juego),
        .jugador_inicial (jugador_inicial),
        .jugador_actual  (jugador_actual),
        .listo           (listo),
        .turno_expirado  (turno_expirado),
        .tiempo_restante (tiempo_restante),
        .numero_turno    (numero_turno),
        .empate          (empate)
    );

    always #5 clk = ~clk;

    int errores = 0;
    int checks  = 0;

    // Behavioural model: game phase, players and counters as plain integers;
    // pulsos holds the button level seen at the last three clock edges.
    int m_est, m_act, m_ini, m_t, m_num, m_emp, m_exp;
    int pulsos [3];

    typedef struct {
        int b; int ini; int jv; int fin;
        int act; int ini_e; int listo; int num; int emp;
    } vec_t;

    vec_t tabla [25];

    task automatic chk(input string nombre, input logic [31:0] act, input int esp);
        checks++;
        if (act !== 32'(esp)) begin
            errores++;
            $display("FAIL %s: got %0d expected %0d at %0t", nombre, act, esp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_est = S_SEL; m_act = 0; m_ini = 0; m_t = 0;
        m_num = 0; m_emp = 0; m_exp = 0;
        for (int k = 0; k < 3; k++) pulsos[k] = 0;
    endtask

    task automatic modelo_paso(input int b, input int ini, input int jv, input int fin);
        int press;
        // A press is seen once the level has been high for two edges after being low
        press = (pulsos[1] != 0 && pulsos[2] == 0) ? 1 : 0;
        pulsos[2] = pulsos[1];
        pulsos[1] = pulsos[0];
        pulsos[0] = b;
        m_exp = 0;
        if (m_est == S_SEL) begin
            if (ini != 0) begin
                m_ini = m_act; m_t = T - 1; m_num = 0; m_emp = 0; m_est = S_JUG;
            end else if (press != 0) begin
                m_act = (m_act + 1) % N;
            end
        end else if (m_est == S_JUG) begin
            if (fin != 0) begin
                m_est = S_FIN;
            end else if (jv != 0) begin
                m_num = m_num + 1;
                m_act = (m_act + 1) % N;
                m_t   = T - 1;
                if (m_num == M) begin
                    m_est = S_FIN; m_emp = 1;
                end
            end else if (m_t == 0) begin
                m_act = (m_act + 1) % N; m_t = T - 1; m_exp = 1;
            end else begin
                m_t = m_t - 1;
            end
        end else begin
            if (press != 0) begin
                m_est = S_SEL;
                m_act = (m_ini + 1) % N;
            end
        end
    endtask

    task automatic revisar_modelo();
        chk("jugador_actual",  32'(jugador_actual),  m_act);
        chk("jugador_inicial", 32'(jugador_inicial), m_ini);
        chk("listo",           32'(listo),           int'(m_est != S_SEL));
        chk("turno_expirado",  32'(turno_expirado),  m_exp);
        chk("tiempo_restante", 32'(tiempo_restante), m_t);
        chk("numero_turno",    32'(numero_turno),    m_num);
        chk("empate",          32'(empate),          m_emp);
    endtask

    // Called at a falling edge: check, drive, advance model, wait one cycle
    task automatic ciclo(input int b, input int ini, input int jv, input int fin);
        revisar_modelo();
        boton_elegir  = (b != 0);
        iniciar_juego = (ini != 0);
        jugada_valida = (jv != 0);
        fin_juego     = (fin != 0);
        modelo_paso(b, ini, jv, fin);
        @(negedge clk);
    endtask

    initial begin
        int b_lvl;
        //            b ini jv fin  act ini listo num emp
        tabla[0]  = '{1, 0, 0, 0,   0, 0, 0, 0, 0};
        tabla[1]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
        tabla[2]  = '{0, 0, 0, 0,   1, 0, 0, 0, 0};
        tabla[3]  = '{1, 0, 0, 0,   1, 0, 0, 0, 0};
        tabla[4]  = '{0, 0, 0, 0,   1, 0, 0, 0, 0};
        tabla[5]  = '{0, 0, 0, 0,   2, 0, 0, 0, 0};
        tabla[6]  = '{1, 0, 0, 0,   2, 0, 0, 0, 0};
        tabla[7]  = '{0, 0, 0, 0,   2, 0, 0, 0, 0};
        tabla[8]  = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
        tabla[9]  = '{1, 0, 0, 0,   0, 0, 0, 0, 0};
        tabla[10] = '{0, 0, 0, 0,   0, 0, 0, 0, 0};
        tabla[11] = '{0, 0, 0, 0,   1, 0, 0, 0, 0};
        tabla[12] = '{0, 1, 0, 0,   1, 1, 1, 0, 0};
        tabla[13] = '{0, 0, 1, 0,   2, 1, 1, 1, 0};
        tabla[14] = '{0, 0, 1, 0,   0, 1, 1, 2, 0};
        tabla[15] = '{0, 0, 1, 1,   0, 1, 1, 2, 0};
        tabla[16] = '{1, 1, 0, 0,   0, 1, 1, 2, 0};
        tabla[17] = '{0, 0, 0, 0,   0, 1, 1, 2, 0};
        tabla[18] = '{0, 0, 0, 0,   2, 1, 0, 2, 0};
        tabla[19] = '{0, 1, 0, 0,   2, 2, 1, 0, 0};
        tabla[20] = '{0, 0, 1, 0,   0, 2, 1, 1, 0};
        tabla[21] = '{0, 0, 1, 0,   1, 2, 1, 2, 0};
        tabla[22] = '{0, 0, 1, 0,   2, 2, 1, 3, 0};
        tabla[23] = '{0, 0, 1, 0,   0, 2, 1, 4, 1};
        tabla[24] = '{0, 0, 1, 0,   0, 2, 1, 4, 1};

        modelo_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            ciclo(tabla[i].b, tabla[i].ini, tabla[i].jv, tabla[i].fin);
            chk("tabla_jugador_actual",  32'(jugador_actual),  tabla[i].act);
            chk("tabla_jugador_inicial", 32'(jugador_inicial), tabla[i].ini_e);
            chk("tabla_listo",           32'(listo),           tabla[i].listo);
            chk("tabla_numero_turno",    32'(numero_turno),    tabla[i].num);
            chk("tabla_empate",          32'(empate),          tabla[i].emp);
        end

        // Press in FIN rotates the opener: (2+1) mod 3 = 0
        ciclo(1, 0, 0, 0); ciclo(0, 0, 0, 0); ciclo(0, 0, 0, 0);
        chk("fin_rotacion_act", 32'(jugador_actual), 0);
        chk("fin_rotacion_listo", 32'(listo), 0);
        ciclo(1, 0, 0, 0); ciclo(0, 0, 0, 0); ciclo(0, 0, 0, 0);
        chk("candidato_1", 32'(jugador_actual), 1);
        // Press edge and start in the same cycle: start wins, candidate 1 locked
        ciclo(1, 0, 0, 0); ciclo(0, 0, 0, 0); ciclo(0, 1, 0, 0);
        chk("empate_inicio_ini", 32'(jugador_inicial), 1);
        chk("empate_inicio_act", 32'(jugador_actual), 1);
        chk("empate_inicio_t", 32'(tiempo_restante), T - 1);

        // Idle turn: expiry pulse exactly T cycles after the start
        for (int i = 0; i < T - 1; i++) begin
            ciclo(0, 0, 0, 0);
            chk("timeout_sin_pulso", 32'(turno_expirado), 0);
        end
        chk("timeout_cero", 32'(tiempo_restante), 0);
        ciclo(0, 0, 0, 0);
        chk("timeout_pulso", 32'(turno_expirado), 1);
        chk("timeout_act", 32'(jugador_actual), 2);
        chk("timeout_t", 32'(tiempo_restante), T - 1);
        chk("timeout_num", 32'(numero_turno), 0);
        ciclo(0, 0, 0, 0);
        chk("timeout_pulso_fin", 32'(turno_expirado), 0);

        // Move on the cycle the timer reads 0 counts as a move, no expiry
        for (int i = 0; i < T - 2; i++) ciclo(0, 0, 0, 0);
        chk("jv_cero_t", 32'(tiempo_restante), 0);
        ciclo(0, 0, 1, 0);
        chk("jv_cero_exp", 32'(turno_expirado), 0);
        chk("jv_cero_num", 32'(numero_turno), 1);
        chk("jv_cero_t_recarga", 32'(tiempo_restante), T - 1);
        chk("jv_cero_act", 32'(jugador_actual), 0);

        // Asynchronous reset mid-game, observed before the next rising edge
        #2 reset_n = 1'b0;
        #1;
        chk("rst_act",   32'(jugador_actual),  0);
        chk("rst_ini",   32'(jugador_inicial), 0);
        chk("rst_listo", 32'(listo),           0);
        chk("rst_exp",   32'(turno_expirado),  0);
        chk("rst_t",     32'(tiempo_restante), 0);
        chk("rst_num",   32'(numero_turno),    0);
        chk("rst_emp",   32'(empate),          0);
        modelo_reset();
        @(negedge clk);
        reset_n = 1'b1;

        b_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                modelo_reset();
                @(negedge clk);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) b_lvl = 1 - b_lvl;
            ciclo(b_lvl,
                  int'($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 29) == 0));
        end
        revisar_modelo();

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

endmodule
